// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA widths, instruction field bounds, reset PC and fetch types
package isa_pkg;
  localparam int ADDR_W     = 8;
  localparam int INS_W      = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 9;
  localparam int R1_MSB     = 8;
  localparam int R1_LSB     = 6;
  localparam int R2_MSB     = 5;
  localparam int R2_LSB     = 3;
  localparam int R3_MSB     = 2;
  localparam int R3_LSB     = 0;
  localparam int IMM6_MSB   = 5;
  localparam int IMM6_LSB   = 0;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
  typedef enum logic {RUN, HALTED} fetch_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
  } fetch_entry_t;
endpackage

// File: rtl/ins_fetch_if.sv
// ins_fetch_if: fetch-stage bus (instruction memory, redirect/halt control, decode handshake)
interface ins_fetch_if;
  import isa_pkg::*;
  logic [ADDR_W-1:0] Addr;
  logic [INS_W-1:0]  Ins;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt;
  logic              ir_valid;
  logic              ir_ready;
  logic [INS_W-1:0]  IR;
  logic [ADDR_W-1:0] PC_out;
  modport master (output Addr, ir_valid, IR, PC_out, input Ins, jump_en, jump_addr, halt, ir_ready);
  modport slave  (input Addr, ir_valid, IR, PC_out, output Ins, jump_en, jump_addr, halt, ir_ready);
endinterface

// File: rtl/ins_fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {pc, ins}; flush dominates push and pop
module fetch_fifo
  import isa_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [PW:0]  r_wr, r_rd;
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
  assign o_data  = r_mem[r_rd[PW-1:0]];
  // pointer update; the extra MSB tells full from empty
  always_ff @(posedge clk)
    if (!rst_n || i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  // storage write; contents are only observed through the gated head
  always_ff @(posedge clk)
    if (rst_n && !i_flush && i_push) r_mem[r_wr[PW-1:0]] <= i_data;
endmodule

// File: rtl/ins_fetch.sv
// ins_fetch: PC, RUN/HALTED FSM and fetch FIFO feeding decode; FETCH_PERF_EN adds fetch_cnt
module ins_fetch
  import isa_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ins_fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_cnt
`endif
);
  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              w_push, w_pop, w_full, w_empty;
  fetch_entry_t      w_head;
  assign w_pop         = !w_empty && bus.ir_ready;
  assign w_push        = (r_state == RUN) && !bus.jump_en && (!w_full || w_pop);
  assign bus.Addr      = r_pc;
  assign bus.ir_valid  = !w_empty;
  assign bus.IR        = w_empty ? '0 : w_head.ins;
  assign bus.PC_out    = w_empty ? '0 : w_head.pc;
  // next state follows the halt level
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = bus.halt ? HALTED : RUN;
  end
  // state register
  always_ff @(posedge clk)
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  // PC: redirect wins over sequential advance; wraps modulo 2^ADDR_W
  always_ff @(posedge clk)
    if (!rst_n)            r_pc <= RESET_PC;
    else if (bus.jump_en)  r_pc <= bus.jump_addr;
    else if (w_push)       r_pc <= r_pc + 1'b1;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.jump_en),
    .i_data  ('{pc: r_pc, ins: bus.Ins}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`ifdef FETCH_PERF_EN
  logic [15:0] r_cnt;
  assign fetch_cnt = r_cnt;
  // saturating push counter, survives redirects
  always_ff @(posedge clk)
    if (!rst_n)                       r_cnt <= '0;
    else if (w_push && r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
`endif
endmodule
